aes_round_engine: RTL
=====================

Name: aes_round_engine

Overview:
Iterative AES-128 encryption datapath and controller, one round per clock. Sits directly upstream of the per-round cipher-state memory and writes each round's output state into it over its write port (data, round index, write enable).
Round keys come from the key-schedule storage over a combinational index/data read. After the final round the block presents the ciphertext and pulses done.

Parameters:
NR, 10, number of AES rounds; fixed at 10 for AES-128, and only 10 is supported.
W, 128, state and round-key width in bits.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to encrypt data_in; sampled only while ready=1.
data_in  input  128  plaintext, AES byte order: bits [127:120] are byte 0.
ready  output  1  high in IDLE; the block accepts start.
busy  output  1  high while rounds are executing.
done  output  1  one-cycle pulse when the ciphertext is valid.
data_out  output  128  ciphertext; holds until the next accepted start.
key_index  output  4  round-key index into key-schedule storage.
round_key  input  128  key for key_index; combinational, same cycle.
mem_we  output  1  write enable to the cipher-state memory.
mem_round_index  output  4  round index to the cipher-state memory.
mem_data  output  128  round-output state to the cipher-state memory.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - FSM=IDLE, rnd=0, state=0, data_out=0, done=0.
  - ready=1, busy=0, mem_we=0.
- FSM states are IDLE, RUN and FINISH.
- IDLE:
  - key_index=0, mem_we=0.
  - On start=1, at that edge: state <= data_in XOR round_key (the initial AddRoundKey with key 0), rnd <= 1, go to RUN.
- RUN:
  - key_index=rnd.
  - The round result is computed combinationally from state: SubBytes (16 S-boxes), then ShiftRows, then MixColumns, then AddRoundKey(round_key). MixColumns is skipped when rnd==NR.
  - mem_data = round result, mem_we=1, mem_round_index=rnd-1, so rounds 1..10 write indices 0..9. These outputs are combinational, and the memory captures them on the same edge that updates state.
  - At each edge: state <= result.
    - If rnd<NR: rnd <= rnd+1.
    - If rnd==NR: data_out <= result, go to FINISH.
- FINISH:
  - done=1 (registered) for exactly one cycle, mem_we=0, busy=0, ready=0.
  - Next edge goes to IDLE.
- Latency: the start edge is followed by 10 RUN cycles and then 1 FINISH cycle. done is asserted 11 cycles after the start edge. Back-to-back throughput is 1 block per 12 cycles.
- Arithmetic:
  - MixColumns is in GF(2^8) with xtime(b) = (b<<1) XOR (b[7] ? 8'h1b : 0), truncated to 8 bits.
  - ShiftRows acts on a column-major state: byte index = 4*col + row.
- Boundary conditions:
  - start while busy or in FINISH is ignored. There is no queueing, and data_out is unchanged.
  - start held high continuously in IDLE starts a new block each time IDLE is re-entered.
  - rst asserted in RUN: returns to IDLE on that edge. No further writes occur; writes already performed remain in memory. No done pulse is generated and data_out is cleared to 0.
  - rst and start high together: rst wins.
  - mem_we is never high outside RUN, and mem_round_index never exceeds 9.
  - key_index never exceeds 10.

Decomposition:
- aes_pkg holds:
  - NR=10 and W=128.
  - The 256-entry S-box constant.
  - The xtime and mix-column functions.
  - The FSM state encodings (IDLE=2'd0, RUN=2'd1, FINISH=2'd2).
- One sub-module, aes_sbox: 8-bit input to 8-bit output, combinational lookup on the package table, instantiated 16 times.
- ShiftRows, MixColumns and AddRoundKey stay inline in aes_round_engine.

Test Plan:
1. FIPS-197 App. B vector. Bench models key storage with the expanded key for 2b7e151628aed2a6abf7158809cf4f3c; pt=3243f6a8885a308d313198a2e0370734.
   - done 11 cycles after start, data_out=3925841d02dc09fbdc118597196a0b32.
   - The mem_round_index=0 write carries a49c7ff2689f352b6b5bea43026a5049.
2. FIPS-197 App. C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
   - data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
   - Index 0 write is 89d810e8855ace682d1843d8cb128fe4.
   - Exactly 10 writes occur, at indices 0..9 in order.
3. start pulsed again at rounds 3 and 10 of a running block -> ignored; the result is identical to scenario 1 and ready stays 0 until after FINISH.
4. rst asserted during round 5 -> next cycle IDLE, ready=1, mem_we=0, data_out=0, no done.
   - A new start afterwards completes correctly with the scenario 2 result.
5. start held high for 30 cycles -> two complete encryptions with done pulses 12 cycles apart, and a third one in progress.
6. Reset release -> ready=1, busy=0, done=0, mem_we=0, key_index=0 on the first cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, types and GF(2^8) helpers for the AES-128 round engine.
package aes_pkg;

  localparam int NR = 10;   // AES-128 round count
  localparam int W  = 128;  // state / round-key width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } fsm_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; row 0 sits in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_engine_sbox.sv
// Single AES S-box: combinational byte lookup in the package table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry b lives at bit 2047-8b, which is {~b, 3'b111}.
  assign out_byte = SBOX[{~in_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one round per clock, each round's
// output state written to the external cipher-state memory.
module aes_round_engine
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   data_in,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   data_out,
  output logic [3:0]     key_index,
  input  logic [W-1:0]   round_key,
  output logic           mem_we,
  output logic [3:0]     mem_round_index,
  output logic [W-1:0]   mem_data
);

  fsm_t         fsm_reg, fsm_next;
  logic [3:0]   rnd_reg, rnd_next;
  logic [W-1:0] blk_reg, blk_next;
  logic [W-1:0] dout_reg, dout_next;
  logic         done_reg, done_next;

  logic [7:0]   sb_bytes [16];
  logic [W-1:0] sr_state;
  logic [W-1:0] mc_state;
  logic [W-1:0] round_out;

  // SubBytes (byte i of the state is bits [127-8i -: 8]) and ShiftRows:
  // output byte (col,row) takes input column (col+row) mod 4, same row.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
    aes_sbox u_sbox (
      .in_byte (blk_reg[W-1-8*gi -: 8]),
      .out_byte(sb_bytes[gi])
    );
    assign sr_state[W-1-8*gi -: 8] = sb_bytes[SRC];
  end

  // MixColumns, one 32-bit column per instance.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mc_state[W-1-32*gi -: 32] = mix_column(sr_state[W-1-32*gi -: 32]);
  end

  // Final round skips MixColumns; AddRoundKey closes every round.
  assign round_out = ((rnd_reg == 4'(NR)) ? sr_state : mc_state) ^ round_key;

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    fsm_next  = fsm_reg;
    rnd_next  = rnd_reg;
    blk_next  = blk_reg;
    dout_next = dout_reg;
    done_next = 1'b0;
    case (fsm_reg)
      IDLE: begin
        if (start) begin
          blk_next = data_in ^ round_key;
          rnd_next = 4'd1;
          fsm_next = RUN;
        end
      end
      RUN: begin
        blk_next = round_out;
        if (rnd_reg == 4'(NR)) begin
          dout_next = round_out;
          done_next = 1'b1;
          fsm_next  = FINISH;
        end else begin
          rnd_next = rnd_reg + 4'd1;
        end
      end
      FINISH: begin
        rnd_next = 4'd0;
        fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg  <= IDLE;
      rnd_reg  <= 4'd0;
      blk_reg  <= '0;
      dout_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      fsm_reg  <= fsm_next;
      rnd_reg  <= rnd_next;
      blk_reg  <= blk_next;
      dout_reg <= dout_next;
      done_reg <= done_next;
    end
  end

  // Status, key-read and memory-write outputs decoded from the state.
  // The write enable is masked by rst so a reset edge never commits a round.
  always_comb begin
    ready           = 1'b0;
    busy            = 1'b0;
    key_index       = 4'd0;
    mem_we          = 1'b0;
    mem_round_index = 4'd0;
    mem_data        = round_out;
    case (fsm_reg)
      IDLE: ready = 1'b1;
      RUN: begin
        busy            = 1'b1;
        key_index       = rnd_reg;
        mem_we          = !rst;
        mem_round_index = rnd_reg - 4'd1;
      end
      default: ;
    endcase
  end

  assign data_out = dout_reg;
  assign done     = done_reg;

endmodule
